// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared pointer-coding helpers for the asynchronous FIFO.
//                Both the read and the write pointer blocks use these, so the
//                two clock domains agree on the Gray/binary mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helpers handle. Narrower pointers are zero-extended
    // going in, and the caller takes the low bits coming out.
    localparam int unsigned FIFO_PTR_MAX_W = 32;

    typedef logic [FIFO_PTR_MAX_W-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary. Each bit is the XOR of all Gray bits at
    // or above it. Zero-extended upper bits leave the low result unchanged.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = '0;
        bin[FIFO_PTR_MAX_W-1] = gray[FIFO_PTR_MAX_W-1];
        for (int i = FIFO_PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_read_pointer_empty.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_pointer_empty
//  Description : Read-side pointer and status logic of an asynchronous FIFO.
//                Keeps the binary read pointer, publishes its Gray form to the
//                write domain, and derives the empty, almost-empty and
//                fill-level flags against the synchronized write pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_pointer_empty
    import fifo_pkg::*;
#(
    parameter  int NUM_ADDRESS            = 8,
    parameter  int ALMOST_EMPTY_THRESHOLD = 2,
    localparam int ADDR_WIDTH             = $clog2(NUM_ADDRESS)
) (
    input  logic                  read_clk,
    input  logic                  read_reset,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   write_pointer_sync,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  fifo_empty,
    output logic                  fifo_almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  read_valid,
    output logic                  underflow
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] C_AE_THRESHOLD = ALMOST_EMPTY_THRESHOLD[ADDR_WIDTH:0];

    // Binary read pointer; one extra MSB distinguishes full from empty.
    logic [ADDR_WIDTH:0] r_rbin;

    logic                w_accept;
    logic                w_read_on_empty;
    logic [ADDR_WIDTH:0] w_rbin_next;
    ptr_word_t           w_rgray_full;
    ptr_word_t           w_wbin_full;
    logic [ADDR_WIDTH:0] w_fill_next;
    logic                w_empty_next;
    logic                w_almost_empty_next;

    // A read is taken only against the registered empty flag, so the
    // consumer sees a stable accept decision for the whole cycle.
    assign w_accept        = read_enable & ~fifo_empty;
    assign w_read_on_empty = read_enable &  fifo_empty;

    // Next pointer and flags. Flags are computed from the post-read pointer
    // and the current synchronized write pointer, so a read and a write on
    // the same edge are both reflected in the registered flags.
    always_comb begin
        w_rbin_next         = r_rbin + {{ADDR_WIDTH{1'b0}}, w_accept};
        w_rgray_full        = bin2gray(ptr_word_t'(w_rbin_next));
        w_wbin_full         = gray2bin(ptr_word_t'(write_pointer_sync));
        w_fill_next         = w_wbin_full[ADDR_WIDTH:0] - w_rbin_next;
        w_empty_next        = (w_rgray_full == ptr_word_t'(write_pointer_sync));
        w_almost_empty_next = (w_fill_next <= C_AE_THRESHOLD);
    end

    // Upper bits of the widened conversion are always zero for a pointer of
    // PTR_WIDTH bits; they are folded here only so they are not left dangling.
    logic w_unused_wbin_hi;
    assign w_unused_wbin_hi = ^w_wbin_full[FIFO_PTR_MAX_W-1:PTR_WIDTH];

    // Pointer, flag and status registers; reset overrides any read request.
    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            r_rbin            <= '0;
            read_pointer      <= '0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
            fill_level        <= '0;
            read_valid        <= 1'b0;
            underflow         <= 1'b0;
        end else begin
            r_rbin            <= w_rbin_next;
            read_pointer      <= w_rgray_full[ADDR_WIDTH:0];
            fifo_empty        <= w_empty_next;
            fifo_almost_empty <= w_almost_empty_next;
            fill_level        <= w_fill_next;
            read_valid        <= w_accept;
            if (w_read_on_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Memory address comes straight from the pointer register.
    assign read_address = r_rbin[ADDR_WIDTH-1:0];

endmodule : fifo_read_pointer_empty
`default_nettype wire

// File: tb/tb_fifo_read_pointer_empty.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_pointer_empty
//  Description : Directed self-checking bench for fifo_read_pointer_empty
//                with NUM_ADDRESS=8, ALMOST_EMPTY_THRESHOLD=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_pointer_empty;

    logic       clk;
    logic       rst;
    logic       read_enable;
    logic [3:0] write_pointer_sync;
    logic [3:0] read_pointer;
    logic [2:0] read_address;
    logic       fifo_empty;
    logic       fifo_almost_empty;
    logic [3:0] fill_level;
    logic       read_valid;
    logic       underflow;

    int vectors;
    int miscompares;

    // Gray code of 0..15, written out by hand.
    logic [3:0] gtab [0:15];

    fifo_read_pointer_empty #(
        .NUM_ADDRESS            (8),
        .ALMOST_EMPTY_THRESHOLD (2)
    ) dut (
        .read_clk           (clk),
        .read_reset         (rst),
        .read_enable        (read_enable),
        .write_pointer_sync (write_pointer_sync),
        .read_pointer       (read_pointer),
        .read_address       (read_address),
        .fifo_empty         (fifo_empty),
        .fifo_almost_empty  (fifo_almost_empty),
        .fill_level         (fill_level),
        .read_valid         (read_valid),
        .underflow          (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; read_enable = 1'b0; write_pointer_sync = 4'b0000;
        step(); step();
        vectors++; if (read_pointer !== 4'b0000) begin miscompares++; $display("FAIL reset.read_pointer got %b exp 0000", read_pointer); end
        vectors++; if (read_address !== 3'b000) begin miscompares++; $display("FAIL reset.read_address got %b exp 000", read_address); end
        vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset.fifo_empty got %b exp 1", fifo_empty); end
        vectors++; if (fifo_almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset.almost_empty got %b exp 1", fifo_almost_empty); end
        vectors++; if (fill_level !== 4'd0) begin miscompares++; $display("FAIL reset.fill_level got %0d exp 0", fill_level); end
        vectors++; if (read_valid !== 1'b0) begin miscompares++; $display("FAIL reset.read_valid got %b exp 0", read_valid); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset.underflow got %b exp 0", underflow); end
    endtask

    task automatic test_fill();
        rst = 1'b0; write_pointer_sync = 4'b0111;
        step();
        vectors++; if (fifo_empty !== 1'b0) begin miscompares++; $display("FAIL fill.fifo_empty got %b exp 0", fifo_empty); end
        vectors++; if (fill_level !== 4'd5) begin miscompares++; $display("FAIL fill.fill_level got %0d exp 5", fill_level); end
        vectors++; if (fifo_almost_empty !== 1'b0) begin miscompares++; $display("FAIL fill.almost_empty got %b exp 0", fifo_almost_empty); end
    endtask

    task automatic test_read_burst();
        logic [3:0] exp_rp [1:5];
        logic [3:0] exp_fill;
        logic       exp_ae;
        exp_rp[1] = 4'b0001; exp_rp[2] = 4'b0011; exp_rp[3] = 4'b0010;
        exp_rp[4] = 4'b0110; exp_rp[5] = 4'b0111;
        read_enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            vectors++; if (read_address !== 3'(k - 1)) begin miscompares++; $display("FAIL burst.read_address[%0d] got %0d exp %0d", k, read_address, k - 1); end
            step();
            exp_fill = 4'(5 - k);
            exp_ae   = (k >= 3);
            vectors++; if (read_pointer !== exp_rp[k]) begin miscompares++; $display("FAIL burst.read_pointer[%0d] got %b exp %b", k, read_pointer, exp_rp[k]); end
            vectors++; if (fill_level !== exp_fill) begin miscompares++; $display("FAIL burst.fill_level[%0d] got %0d exp %0d", k, fill_level, exp_fill); end
            vectors++; if (fifo_almost_empty !== exp_ae) begin miscompares++; $display("FAIL burst.almost_empty[%0d] got %b exp %b", k, fifo_almost_empty, exp_ae); end
            vectors++; if (fifo_empty !== (k == 5)) begin miscompares++; $display("FAIL burst.fifo_empty[%0d] got %b exp %b", k, fifo_empty, (k == 5)); end
            vectors++; if (read_valid !== 1'b1) begin miscompares++; $display("FAIL burst.read_valid[%0d] got %b exp 1", k, read_valid); end
        end
        read_enable = 1'b0;
        step();
        vectors++; if (read_valid !== 1'b0) begin miscompares++; $display("FAIL burst.read_valid_end got %b exp 0", read_valid); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL burst.underflow got %b exp 0", underflow); end
    endtask

    task automatic test_underflow();
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
        vectors++; if (read_pointer !== 4'b0111) begin miscompares++; $display("FAIL uflow.read_pointer got %b exp 0111", read_pointer); end
        vectors++; if (read_address !== 3'd5) begin miscompares++; $display("FAIL uflow.read_address got %0d exp 5", read_address); end
        vectors++; if (read_valid !== 1'b0) begin miscompares++; $display("FAIL uflow.read_valid got %b exp 0", read_valid); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uflow.underflow got %b exp 1", underflow); end
        repeat (10) step();
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uflow.sticky got %b exp 1", underflow); end
        vectors++; if (read_pointer !== 4'b0111) begin miscompares++; $display("FAIL uflow.hold_pointer got %b exp 0111", read_pointer); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_fill;
        // Restart from pointer zero so twelve reads cross the address wrap.
        rst = 1'b1; read_enable = 1'b0; write_pointer_sync = 4'b0000;
        step();
        rst = 1'b0;
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL wrap.underflow_cleared got %b exp 0", underflow); end
        for (int n = 1; n <= 12; n++) begin
            write_pointer_sync = gtab[n];
            step();
            vectors++; if (fill_level !== 4'(n)) begin miscompares++; $display("FAIL wrap.step_fill[%0d] got %0d exp %0d", n, fill_level, n); end
        end
        read_enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            vectors++; if (read_address !== 3'((k - 1) % 8)) begin miscompares++; $display("FAIL wrap.read_address[%0d] got %0d exp %0d", k, read_address, (k - 1) % 8); end
            step();
            exp_fill = 4'(12 - k);
            vectors++; if (fill_level !== exp_fill) begin miscompares++; $display("FAIL wrap.fill_level[%0d] got %0d exp %0d", k, fill_level, exp_fill); end
            vectors++; if (fifo_empty !== (k == 12)) begin miscompares++; $display("FAIL wrap.fifo_empty[%0d] got %b exp %b", k, fifo_empty, (k == 12)); end
        end
        read_enable = 1'b0;
        vectors++; if (read_pointer !== 4'b1010) begin miscompares++; $display("FAIL wrap.read_pointer got %b exp 1010", read_pointer); end
        vectors++; if (read_address !== 3'd4) begin miscompares++; $display("FAIL wrap.read_address_end got %0d exp 4", read_address); end
    endtask

    task automatic test_back_to_back();
        // Write side jumps to 14 while read side sits at 12.
        write_pointer_sync = 4'b1001;
        step();
        vectors++; if (fill_level !== 4'd2) begin miscompares++; $display("FAIL b2b.fill_pre got %0d exp 2", fill_level); end
        // Read accepted on the same edge the write pointer moves to 15.
        read_enable = 1'b1; write_pointer_sync = 4'b1000;
        step();
        vectors++; if (read_pointer !== 4'b1011) begin miscompares++; $display("FAIL b2b.read_pointer got %b exp 1011", read_pointer); end
        vectors++; if (fill_level !== 4'd2) begin miscompares++; $display("FAIL b2b.fill_same_edge got %0d exp 2", fill_level); end
        vectors++; if (fifo_empty !== 1'b0) begin miscompares++; $display("FAIL b2b.fifo_empty got %b exp 0", fifo_empty); end
        step(); step();
        read_enable = 1'b0;
        vectors++; if (read_pointer !== 4'b1000) begin miscompares++; $display("FAIL b2b.read_pointer_end got %b exp 1000", read_pointer); end
        vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL b2b.fifo_empty_end got %b exp 1", fifo_empty); end
        vectors++; if (fill_level !== 4'd0) begin miscompares++; $display("FAIL b2b.fill_end got %0d exp 0", fill_level); end
    endtask

    task automatic test_reset_mid();
        // Write pointer at 18 mod 16 = 2 against read pointer 15 gives 3.
        write_pointer_sync = 4'b0011;
        step();
        vectors++; if (fill_level !== 4'd3) begin miscompares++; $display("FAIL rstmid.fill_pre got %0d exp 3", fill_level); end
        read_enable = 1'b1; rst = 1'b1;
        step();
        vectors++; if (read_pointer !== 4'b0000) begin miscompares++; $display("FAIL rstmid.read_pointer got %b exp 0000", read_pointer); end
        vectors++; if (read_address !== 3'd0) begin miscompares++; $display("FAIL rstmid.read_address got %0d exp 0", read_address); end
        vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid.fifo_empty got %b exp 1", fifo_empty); end
        vectors++; if (fifo_almost_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid.almost_empty got %b exp 1", fifo_almost_empty); end
        vectors++; if (fill_level !== 4'd0) begin miscompares++; $display("FAIL rstmid.fill_level got %0d exp 0", fill_level); end
        vectors++; if (read_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid.read_valid got %b exp 0", read_valid); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL rstmid.underflow got %b exp 0", underflow); end
        rst = 1'b0; read_enable = 1'b0; write_pointer_sync = 4'b0000;
        step();
        vectors++; if (read_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid.no_pulse got %b exp 0", read_valid); end
        vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid.empty_after got %b exp 1", fifo_empty); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        gtab[0]  = 4'b0000; gtab[1]  = 4'b0001; gtab[2]  = 4'b0011; gtab[3]  = 4'b0010;
        gtab[4]  = 4'b0110; gtab[5]  = 4'b0111; gtab[6]  = 4'b0101; gtab[7]  = 4'b0100;
        gtab[8]  = 4'b1100; gtab[9]  = 4'b1101; gtab[10] = 4'b1111; gtab[11] = 4'b1110;
        gtab[12] = 4'b1010; gtab[13] = 4'b1011; gtab[14] = 4'b1001; gtab[15] = 4'b1000;
        rst = 1'b1; read_enable = 1'b0; write_pointer_sync = 4'b0000;
        test_reset();
        test_fill();
        test_read_burst();
        test_underflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_read_pointer_empty
`default_nettype wire
